superh16_wakeup_broadcast: RTL and testbench
============================================

// Module: superh16_wakeup_broadcast
// PURPOSE
//  Producer side of the scheduler wakeup bus. Accepts issued uops (dst tag, latency, rob_idx)
//  from the scheduler issue lanes. Holds each one in a latency timing wheel, then drives
//  wakeup_valid/wakeup_tag so dependants in every sched bank become ready exactly when the
//  result is available. Sits between the issue ports and the wakeup CAMs of all banks.
// PARAMETERS
//  N_ISSUE       4    issue lanes accepted per cycle
//  WAKEUP_PORTS  8    broadcast ports (ways per wheel slot)
//  MAX_LAT       8    max exec latency in cycles = number of wheel slots
//  TAG_W         8    physical register tag width
//  ROB_W         9    rob index width
//  LAT_W         4    latency field width, >= $clog2(MAX_LAT+1)
// PORTS
//  clk            in   1                  clock
//  rst_n          in   1                  async active-low reset
//  iss_valid      in   [N_ISSUE]          issue lane valid
//  iss_dst_valid  in   [N_ISSUE]          uop writes a register; 0 -> lane ignored
//  iss_dst_tag    in   [N_ISSUE][TAG_W]   destination physical tag
//  iss_lat        in   [N_ISSUE][LAT_W]   exec latency, 1..MAX_LAT
//  iss_rob_idx    in   [N_ISSUE][ROB_W]   rob index, used for flush
//  flush          in   1                  pipeline flush
//  flush_rob_idx  in   ROB_W              entries with rob_idx > this are cancelled
//  wakeup_valid   out  [WAKEUP_PORTS]     broadcast valid, registered
//  wakeup_tag     out  [WAKEUP_PORTS][TAG_W]  broadcast tag, registered
//  issue_hold     out  1                  registered; scheduler must not issue next cycle
//  wake_overflow  out  1                  sticky error: an entry was dropped
// BEHAVIOUR
//  - Reset: all slots invalid, ptr=0, wakeup_valid=0, wakeup_tag=0, issue_hold=0,
//    wake_overflow=0. Reset mid-operation discards all pending wakeups. No broadcast in the
//    first cycle after release.
//  - Wheel: MAX_LAT slots x WAKEUP_PORTS ways. Each way holds {valid, tag, rob_idx}.
//    ptr (log2 MAX_LAT bits) advances +1 mod MAX_LAT every cycle, with wrap.
//  - Latency: a lane valid in cycle t with latency L gives a wakeup visible in cycle t+L,
//    or later if deferred. Never earlier.
//  - iss_lat = 0 is treated as 1. iss_lat > MAX_LAT is treated as MAX_LAT.
//  - Insert target slot is (ptr+L-1) mod MAX_LAT.
//    L=1 targets slot ptr, which is read at this same edge (bypass path).
//  - Insert order: lanes are processed in order 0..N_ISSUE-1. Each lane takes the lowest
//    free way of its target slot. If the target slot is full (including earlier lanes this
//    cycle), search forward slot by slot up to (ptr+MAX_LAT-1) mod MAX_LAT.
//    Deferral delays a wakeup; it never makes a wakeup early.
//  - No free way in the whole search range: drop the entry and set wake_overflow. It stays
//    set until reset.
//  - Broadcast edge: wakeup_valid/tag <= ways of slot ptr, including same-cycle L=1
//    inserts, in way order. Slot ptr is then cleared.
//  - Flush cycle, applied at the same edge:
//    - cancel every stored way with rob_idx > flush_rob_idx, using plain unsigned compare;
//    - suppress same-cycle inserts with rob_idx > flush_rob_idx;
//    - suppress their broadcast from slot ptr this edge.
//    Older entries are unaffected and keep their slots.
//  - issue_hold <= 1 when the next-state occupancy exceeds MAX_LAT*WAKEUP_PORTS-2*N_ISSUE,
//    else 0.
//  - Simultaneous insert and broadcast on slot ptr: both are legal. New L=1 entries are
//    broadcast and are never stored.
// TESTING
//  1. Cycle 10: lane0 tag=0x2A, L=3. -> wakeup_valid[0]=1, wakeup_tag[0]=0x2A in cycle 13
//     only. All other cycles: wakeup_valid=0.
//  2. Cycle t: lane2 tag=0x11, L=1. -> port0 carries 0x11 in cycle t+1; wheel is empty
//     afterwards.
//  3. Cycle t: 4 lanes L=4. Cycle t+1: 4 lanes L=3. Cycle t+2: 4 lanes L=2, tags 0x40..0x4B.
//     -> 0x40..0x47 at t+4 on ports 0..7; 0x48..0x4B at t+5 on ports 0..3.
//  4. Cycle t: rob 0x10 tag 0x05 L=5, and rob 0x30 tag 0x06 L=5. Flush at t+2 with
//     flush_rob_idx=0x20. -> only 0x05 broadcast, at t+5.
//  5. Fill the wheel with L=MAX_LAT bursts until issue_hold=1, then keep issuing. ->
//     issue_hold asserts while occupancy > 56. wake_overflow stays 0 while the bench obeys
//     hold; it sets to 1 when the bench ignores hold.
//  6. Assert rst_n low with 10 pending entries, then release. -> all outputs 0. No
//     wakeup_valid for 2*MAX_LAT cycles. iss_dst_valid=0 lanes never broadcast.

Source files
------------

// File: rtl/superh16_wakeup_broadcast.sv
// Producer side of the scheduler wakeup bus: issued uops wait in a latency timing wheel
// and are broadcast on the wakeup ports in the cycle their result becomes available.
module superh16_wakeup_broadcast #(
  parameter int N_ISSUE      = 4,
  parameter int WAKEUP_PORTS = 8,
  parameter int MAX_LAT      = 8,
  parameter int TAG_W        = 8,
  parameter int ROB_W        = 9,
  parameter int LAT_W        = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_ISSUE-1:0]                   iss_valid,
  input  logic [N_ISSUE-1:0]                   iss_dst_valid,
  input  logic [N_ISSUE-1:0][TAG_W-1:0]        iss_dst_tag,
  input  logic [N_ISSUE-1:0][LAT_W-1:0]        iss_lat,
  input  logic [N_ISSUE-1:0][ROB_W-1:0]        iss_rob_idx,
  input  logic                                 flush,
  input  logic [ROB_W-1:0]                     flush_rob_idx,
  output logic [WAKEUP_PORTS-1:0]              wakeup_valid,
  output logic [WAKEUP_PORTS-1:0][TAG_W-1:0]   wakeup_tag,
  output logic                                 issue_hold,
  output logic                                 wake_overflow
);

  localparam int PTR_W    = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int CAP      = MAX_LAT * WAKEUP_PORTS;
  localparam int OCC_W    = $clog2(CAP + 1);
  localparam int HOLD_THR = CAP - 2 * N_ISSUE;

  // Clamp the latency field into the legal 1..MAX_LAT window.
  function automatic int sat_lat(input logic [LAT_W-1:0] lat);
    if (lat == '0) return 1;
    if (int'(lat) > MAX_LAT) return MAX_LAT;
    return int'(lat);
  endfunction

  function automatic logic [PTR_W-1:0] slot_at(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % MAX_LAT;
    return PTR_W'(s);
  endfunction

  logic [PTR_W-1:0]                  r_ptr;
  logic [WAKEUP_PORTS-1:0]           r_vld [MAX_LAT];
  logic [TAG_W-1:0]                  r_tag [MAX_LAT][WAKEUP_PORTS];
  logic [ROB_W-1:0]                  r_rob [MAX_LAT][WAKEUP_PORTS];
  logic [WAKEUP_PORTS-1:0]           r_bc_vld_p1;
  logic [WAKEUP_PORTS-1:0][TAG_W-1:0] r_bc_tag_p1;
  logic                              r_hold;
  logic                              r_ovf;

  logic [WAKEUP_PORTS-1:0]           w_vld_n [MAX_LAT];
  logic [TAG_W-1:0]                  w_tag_n [MAX_LAT][WAKEUP_PORTS];
  logic [ROB_W-1:0]                  w_rob_n [MAX_LAT][WAKEUP_PORTS];
  logic [WAKEUP_PORTS-1:0]           w_bc_vld;
  logic [WAKEUP_PORTS-1:0][TAG_W-1:0] w_bc_tag;
  logic [OCC_W-1:0]                  w_occ;
  logic [PTR_W-1:0]                  w_slot;
  logic                              w_placed;
  logic                              w_drop;

  // Stage p0: flush cancel, ordered lane insertion with forward deferral, slot ptr readout.
  always_comb begin
    w_vld_n  = r_vld;
    w_tag_n  = r_tag;
    w_rob_n  = r_rob;
    w_bc_vld = '0;
    w_bc_tag = '0;
    w_occ    = '0;
    w_slot   = '0;
    w_placed = 1'b0;
    w_drop   = 1'b0;

    if (flush) begin
      for (int s = 0; s < MAX_LAT; s++) begin
        for (int w = 0; w < WAKEUP_PORTS; w++) begin
          if (r_rob[s][w] > flush_rob_idx) w_vld_n[s][w] = 1'b0;
        end
      end
    end

    // Cancellation runs first so freed ways are reusable by this cycle's lanes.
    for (int l = 0; l < N_ISSUE; l++) begin
      w_placed = 1'b0;
      if (iss_valid[l] && iss_dst_valid[l] &&
          !(flush && (iss_rob_idx[l] > flush_rob_idx))) begin
        for (int k = 0; k < MAX_LAT; k++) begin
          w_slot = slot_at(r_ptr, k);
          if (!w_placed && (k >= sat_lat(iss_lat[l]) - 1)) begin
            for (int w = 0; w < WAKEUP_PORTS; w++) begin
              if (!w_placed && !w_vld_n[w_slot][w]) begin
                w_vld_n[w_slot][w] = 1'b1;
                w_tag_n[w_slot][w] = iss_dst_tag[l];
                w_rob_n[w_slot][w] = iss_rob_idx[l];
                w_placed           = 1'b1;
              end
            end
          end
        end
        w_drop = w_drop | ~w_placed;
      end
    end

    for (int w = 0; w < WAKEUP_PORTS; w++) begin
      w_bc_vld[w] = w_vld_n[r_ptr][w];
      w_bc_tag[w] = w_vld_n[r_ptr][w] ? w_tag_n[r_ptr][w] : '0;
    end
    w_vld_n[r_ptr] = '0;

    for (int s = 0; s < MAX_LAT; s++) begin
      for (int w = 0; w < WAKEUP_PORTS; w++) begin
        w_occ = w_occ + OCC_W'(w_vld_n[s][w]);
      end
    end
  end

  // Stage p1: wheel state, broadcast registers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_vld       <= '{default: '0};
      r_bc_vld_p1 <= '0;
      r_bc_tag_p1 <= '0;
      r_hold      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_ptr       <= (r_ptr == PTR_W'(MAX_LAT - 1)) ? '0 : r_ptr + 1'b1;
      r_vld       <= w_vld_n;
      r_bc_vld_p1 <= w_bc_vld;
      r_bc_tag_p1 <= w_bc_tag;
      r_hold      <= (int'(w_occ) > HOLD_THR);
      r_ovf       <= r_ovf | w_drop;
    end
  end

  // Payload is only meaningful under its valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    r_tag <= w_tag_n;
    r_rob <= w_rob_n;
  end

  assign wakeup_valid  = r_bc_vld_p1;
  assign wakeup_tag    = r_bc_tag_p1;
  assign issue_hold    = r_hold;
  assign wake_overflow = r_ovf;

endmodule

// File: tb/tb_superh16_wakeup_broadcast.sv
// Directed bench for the wakeup timing wheel: a default-sized instance for timing/flush/reset
// and a 2-way instance small enough to reach the hold and overflow conditions.
module tb_superh16_wakeup_broadcast;
  localparam int NI = 4, WP = 8, ML = 8, TW = 8, RW = 9, LW = 4, WP2 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]          a_vld, a_dv, b_vld, b_dv;
  logic [NI-1:0][TW-1:0]  a_tag, b_tag;
  logic [NI-1:0][LW-1:0]  a_lat, b_lat;
  logic [NI-1:0][RW-1:0]  a_rob, b_rob;
  logic                   a_flush, b_flush;
  logic [RW-1:0]          a_frob, b_frob;
  logic [WP-1:0]          a_wv;
  logic [WP-1:0][TW-1:0]  a_wt;
  logic [WP2-1:0]         b_wv;
  logic [WP2-1:0][TW-1:0] b_wt;
  logic                   a_hold, a_ovf, b_hold, b_ovf;

  int n_vec = 0;
  int n_err = 0;
  logic [WP-1:0]          exp_v;
  logic [WP-1:0][TW-1:0]  exp_t;
  logic [WP2-1:0]         exp_v2;
  logic [WP2-1:0][TW-1:0] exp_t2;
  logic                   exp_h, exp_o;

  superh16_wakeup_broadcast #(.N_ISSUE(NI), .WAKEUP_PORTS(WP), .MAX_LAT(ML), .TAG_W(TW),
                              .ROB_W(RW), .LAT_W(LW)) u_dut (
    .clk(clk), .rst_n(rst_n), .iss_valid(a_vld), .iss_dst_valid(a_dv), .iss_dst_tag(a_tag),
    .iss_lat(a_lat), .iss_rob_idx(a_rob), .flush(a_flush), .flush_rob_idx(a_frob),
    .wakeup_valid(a_wv), .wakeup_tag(a_wt), .issue_hold(a_hold), .wake_overflow(a_ovf));

  superh16_wakeup_broadcast #(.N_ISSUE(NI), .WAKEUP_PORTS(WP2), .MAX_LAT(ML), .TAG_W(TW),
                              .ROB_W(RW), .LAT_W(LW)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .iss_valid(b_vld), .iss_dst_valid(b_dv), .iss_dst_tag(b_tag),
    .iss_lat(b_lat), .iss_rob_idx(b_rob), .flush(b_flush), .flush_rob_idx(b_frob),
    .wakeup_valid(b_wv), .wakeup_tag(b_wt), .issue_hold(b_hold), .wake_overflow(b_ovf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_vld = '0; a_dv = '0; a_tag = '0; a_lat = '0; a_rob = '0; a_flush = 1'b0; a_frob = '0;
    b_vld = '0; b_dv = '0; b_tag = '0; b_lat = '0; b_rob = '0; b_flush = 1'b0; b_frob = '0;
  endtask

  task automatic put_a(input int l, input logic [TW-1:0] tag, input logic [LW-1:0] lat,
                       input logic [RW-1:0] rob);
    a_vld[l] = 1'b1; a_dv[l] = 1'b1; a_tag[l] = tag; a_lat[l] = lat; a_rob[l] = rob;
  endtask

  task automatic put_b(input int l, input logic [TW-1:0] tag, input logic [LW-1:0] lat);
    b_vld[l] = 1'b1; b_dv[l] = 1'b1; b_tag[l] = tag; b_lat[l] = lat; b_rob[l] = '0;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec += 6;
    if (a_wv !== '0) begin n_err++; $display("FAIL reset_valid got %h want 0", a_wv); end
    if (a_wt !== '0) begin n_err++; $display("FAIL reset_tag got %h want 0", a_wt); end
    if (a_hold !== 1'b0) begin n_err++; $display("FAIL reset_hold got %b want 0", a_hold); end
    if (a_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", a_ovf); end
    if (b_hold !== 1'b0) begin n_err++; $display("FAIL reset_hold2 got %b want 0", b_hold); end
    if (b_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf2 got %b want 0", b_ovf); end
    tick();
    n_vec++;
    if (a_wv !== '0) begin n_err++; $display("FAIL reset_first_cycle got %h want 0", a_wv); end
  endtask

  task automatic test_single_l3();
    idle_all();
    put_a(0, 8'h2A, 4'd3, 9'd1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      idle_all();
      exp_v = (i == 3) ? 8'h01 : 8'h00;
      exp_t = '0;
      exp_t[0] = 8'h2A;
      n_vec++;
      if (a_wv !== exp_v) begin n_err++; $display("FAIL single_l3 cyc%0d valid got %h want %h", i, a_wv, exp_v); end
      for (int j = 0; j < WP; j++) if (exp_v[j]) begin
        n_vec++;
        if (a_wt[j] !== exp_t[j]) begin n_err++; $display("FAIL single_l3 cyc%0d tag%0d got %h want %h", i, j, a_wt[j], exp_t[j]); end
      end
    end
  endtask

  task automatic test_l1_bypass();
    idle_all();
    put_a(2, 8'h11, 4'd1, 9'd2);
    for (int i = 1; i <= 9; i++) begin
      tick();
      idle_all();
      exp_v = (i == 1) ? 8'h01 : 8'h00;
      exp_t = '0;
      exp_t[0] = 8'h11;
      n_vec++;
      if (a_wv !== exp_v) begin n_err++; $display("FAIL l1_bypass cyc%0d valid got %h want %h", i, a_wv, exp_v); end
      for (int j = 0; j < WP; j++) if (exp_v[j]) begin
        n_vec++;
        if (a_wt[j] !== exp_t[j]) begin n_err++; $display("FAIL l1_bypass cyc%0d tag%0d got %h want %h", i, j, a_wt[j], exp_t[j]); end
      end
    end
  endtask

  task automatic test_lat_clamp();
    idle_all();
    put_a(0, 8'h21, 4'd0, 9'd3);
    put_a(1, 8'h22, 4'd15, 9'd4);
    for (int i = 1; i <= 9; i++) begin
      tick();
      idle_all();
      exp_v = (i == 1 || i == 8) ? 8'h01 : 8'h00;
      exp_t = '0;
      exp_t[0] = (i == 1) ? 8'h21 : 8'h22;
      n_vec++;
      if (a_wv !== exp_v) begin n_err++; $display("FAIL lat_clamp cyc%0d valid got %h want %h", i, a_wv, exp_v); end
      for (int j = 0; j < WP; j++) if (exp_v[j]) begin
        n_vec++;
        if (a_wt[j] !== exp_t[j]) begin n_err++; $display("FAIL lat_clamp cyc%0d tag%0d got %h want %h", i, j, a_wt[j], exp_t[j]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    idle_all();
    for (int l = 0; l < NI; l++) put_a(l, 8'(8'h40 + l), 4'd4, 9'(l));
    for (int i = 1; i <= 7; i++) begin
      tick();
      idle_all();
      if (i == 1) for (int l = 0; l < NI; l++) put_a(l, 8'(8'h44 + l), 4'd3, 9'(l));
      if (i == 2) for (int l = 0; l < NI; l++) put_a(l, 8'(8'h48 + l), 4'd2, 9'(l));
      exp_v = (i == 4) ? 8'hFF : (i == 5) ? 8'h0F : 8'h00;
      for (int j = 0; j < WP; j++) exp_t[j] = (i == 4) ? 8'(8'h40 + j) : 8'(8'h48 + j);
      n_vec++;
      if (a_wv !== exp_v) begin n_err++; $display("FAIL back_to_back cyc%0d valid got %h want %h", i, a_wv, exp_v); end
      for (int j = 0; j < WP; j++) if (exp_v[j]) begin
        n_vec++;
        if (a_wt[j] !== exp_t[j]) begin n_err++; $display("FAIL back_to_back cyc%0d tag%0d got %h want %h", i, j, a_wt[j], exp_t[j]); end
      end
      if (i == 3) begin
        n_vec++;
        if (a_hold !== 1'b0) begin n_err++; $display("FAIL back_to_back_hold got %b want 0", a_hold); end
      end
    end
  endtask

  task automatic test_flush();
    idle_all();
    put_a(0, 8'h05, 4'd5, 9'h010);
    put_a(1, 8'h06, 4'd5, 9'h030);
    put_a(3, 8'h07, 4'd3, 9'h031);
    for (int i = 1; i <= 7; i++) begin
      tick();
      idle_all();
      if (i == 2) begin
        a_flush = 1'b1;
        a_frob  = 9'h020;
        put_a(0, 8'h77, 4'd1, 9'h040);
        put_a(1, 8'h78, 4'd1, 9'h005);
        put_a(2, 8'h79, 4'd1, 9'h020);
      end
      exp_v = (i == 3) ? 8'h03 : (i == 5) ? 8'h01 : 8'h00;
      exp_t = '0;
      exp_t[0] = (i == 3) ? 8'h78 : 8'h05;
      exp_t[1] = 8'h79;
      n_vec++;
      if (a_wv !== exp_v) begin n_err++; $display("FAIL flush cyc%0d valid got %h want %h", i, a_wv, exp_v); end
      for (int j = 0; j < WP; j++) if (exp_v[j]) begin
        n_vec++;
        if (a_wt[j] !== exp_t[j]) begin n_err++; $display("FAIL flush cyc%0d tag%0d got %h want %h", i, j, a_wt[j], exp_t[j]); end
      end
    end
  endtask

  task automatic test_hold_overflow();
    // Obeying hold: three bursts of 4 lanes at L=5 on the 2-way wheel.
    idle_all();
    for (int l = 0; l < NI; l++) put_b(l, 8'(8'h80 + l), 4'd5);
    for (int i = 1; i <= 11; i++) begin
      tick();
      idle_all();
      if (i <= 2) for (int l = 0; l < NI; l++) put_b(l, 8'(8'h80 + i * 4 + l), 4'd5);
      exp_h  = (i >= 3 && i <= 5);
      exp_o  = 1'b0;
      exp_v2 = (i >= 5 && i <= 10) ? 2'b11 : 2'b00;
      exp_t2[0] = 8'(8'h80 + (i - 5) * 2);
      exp_t2[1] = 8'(8'h81 + (i - 5) * 2);
      n_vec += 3;
      if (b_hold !== exp_h) begin n_err++; $display("FAIL hold cyc%0d got %b want %b", i, b_hold, exp_h); end
      if (b_ovf !== exp_o) begin n_err++; $display("FAIL hold_ovf cyc%0d got %b want %b", i, b_ovf, exp_o); end
      if (b_wv !== exp_v2) begin n_err++; $display("FAIL hold_valid cyc%0d got %b want %b", i, b_wv, exp_v2); end
      for (int j = 0; j < WP2; j++) if (exp_v2[j]) begin
        n_vec++;
        if (b_wt[j] !== exp_t2[j]) begin n_err++; $display("FAIL hold_tag cyc%0d port%0d got %h want %h", i, j, b_wt[j], exp_t2[j]); end
      end
    end
    // Ignoring hold: a fourth burst leaves two lanes with no free way.
    for (int l = 0; l < NI; l++) put_b(l, 8'(8'hC0 + l), 4'd5);
    for (int i = 1; i <= 12; i++) begin
      tick();
      idle_all();
      if (i <= 3) for (int l = 0; l < NI; l++) put_b(l, 8'(8'hC0 + i * 4 + l), 4'd5);
      exp_o = (i >= 4);
      n_vec++;
      if (b_ovf !== exp_o) begin n_err++; $display("FAIL overflow cyc%0d got %b want %b", i, b_ovf, exp_o); end
    end
    n_vec++;
    if (a_ovf !== 1'b0) begin n_err++; $display("FAIL main_overflow got %b want 0", a_ovf); end
  endtask

  task automatic test_reset_midop();
    idle_all();
    for (int l = 0; l < NI; l++) put_a(l, 8'(8'hA0 + l), 4'd8, 9'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      idle_all();
      if (i == 1) for (int l = 0; l < NI; l++) put_a(l, 8'(8'hA4 + l), 4'd8, 9'd1);
      if (i == 2) for (int l = 0; l < 2; l++) put_a(l, 8'(8'hA8 + l), 4'd8, 9'd1);
    end
    n_vec++;
    if (a_wv !== '0) begin n_err++; $display("FAIL midop_pre_valid got %h want 0", a_wv); end
    rst_n = 1'b0;
    #1;
    n_vec += 4;
    if (a_wv !== '0) begin n_err++; $display("FAIL midop_async_valid got %h want 0", a_wv); end
    if (a_wt !== '0) begin n_err++; $display("FAIL midop_async_tag got %h want 0", a_wt); end
    if (a_hold !== 1'b0) begin n_err++; $display("FAIL midop_async_hold got %b want 0", a_hold); end
    if (b_ovf !== 1'b0) begin n_err++; $display("FAIL midop_ovf_cleared got %b want 0", b_ovf); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 2 * ML; i++) begin
      tick();
      idle_all();
      a_vld = '1;
      a_dv  = '0;
      for (int l = 0; l < NI; l++) begin
        a_tag[l] = 8'(8'hE0 + l);
        a_lat[l] = 4'((i % ML) + 1);
      end
      n_vec++;
      if (a_wv !== '0) begin n_err++; $display("FAIL midop_quiet cyc%0d valid got %h want 0", i, a_wv); end
    end
    tick();
    idle_all();
    put_a(0, 8'h5A, 4'd1, 9'd0);
    tick();
    idle_all();
    n_vec += 2;
    if (a_wv !== 8'h01) begin n_err++; $display("FAIL midop_alive valid got %h want 01", a_wv); end
    if (a_wt[0] !== 8'h5A) begin n_err++; $display("FAIL midop_alive tag got %h want 5a", a_wt[0]); end
  endtask

  initial begin
    test_reset();
    test_single_l3();
    test_l1_bypass();
    test_lat_clamp();
    test_back_to_back();
    test_flush();
    test_hold_overflow();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
